fault_test_seq: RTL and testbench

Sequential test controller for the stuck-at fault-comparison datapath. It walks all 16 input vectors (A,B,C,D) through the paired good and faulty circuit copies. For each vector it waits a programmable settling time, then compares the good output Z against the faulted output Z_sa0. It records which vectors detect the fault and reports a summary when the sweep ends. It sits above the combinational fault datapath, drives that datapath's primary inputs and forced-net value, and owns its results registers.

---
 rtl/fault_test_seq.sv | 158 +++++++++++++++
 tb/tb_fault_test_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fault_test_seq.sv
// fault_test_seq: walks the 16 (A,B,C,D) vectors through the good/faulted datapath pair and records which vectors expose the fault.
// Optional feature macro FTS_EARLY_STOP_EN: end the sweep at the first detecting vector instead of sweeping all 16.
module fault_test_seq #(
    parameter logic        STUCK_VAL = 1'b0,
    parameter int unsigned SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        z_good,
    input  logic        z_fault,
    output logic [3:0]  vec,
    output logic        f_force,
    output logic        busy,
    output logic        done,
    output logic        detected,
    output logic [3:0]  first_vec,
    output logic [4:0]  det_count,
    output logic [15:0] det_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter reload gives exactly SETTLE cycles in WAIT (counts SETTLE-1 down to 0).
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 32'd1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [3:0]  vec_r, vec_s;
    logic [15:0] det_mask_r, det_mask_s;
    logic [4:0]  det_count_r, det_count_s;
    logic        detected_r, detected_s;
    logic [3:0]  first_vec_r, first_vec_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        f_force_r, f_force_s;
    logic        mism_s;
    logic        early_stop_s;

    assign mism_s = z_good ^ z_fault;

`ifdef FTS_EARLY_STOP_EN
    assign early_stop_s = mism_s;
`else
    assign early_stop_s = 1'b0;
`endif

    // Next-state and next-value logic for the sweep controller and its result registers
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        vec_s       = vec_r;
        det_mask_s  = det_mask_r;
        det_count_s = det_count_r;
        detected_s  = detected_r;
        first_vec_s = first_vec_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        vec_s       = 4'd0;
                        cnt_s       = CNT_LOAD;
                        det_mask_s  = 16'd0;
                        det_count_s = 5'd0;
                        detected_s  = 1'b0;
                        first_vec_s = 4'd0;
                        state_s     = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_s = ST_CMP;
                    end else begin
                        cnt_s = cnt_r - 8'd1;
                    end
                end
                ST_CMP: begin
                    if (mism_s) begin
                        det_mask_s[vec_r] = 1'b1;
                        det_count_s       = det_count_r + 5'd1;
                        if (!detected_r) begin
                            first_vec_s = vec_r;
                            detected_s  = 1'b1;
                        end else begin
                            first_vec_s = first_vec_r;
                        end
                    end else begin
                        det_count_s = det_count_r;
                    end
                    if ((vec_r == 4'd15) || early_stop_s) begin
                        state_s = ST_DONE;
                    end else begin
                        vec_s   = vec_r + 4'd1;
                        cnt_s   = CNT_LOAD;
                        state_s = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        // Status outputs are registered from the next state so they line up with it.
        busy_s    = (state_s == ST_WAIT) || (state_s == ST_CMP);
        done_s    = (state_s == ST_DONE);
        f_force_s = busy_s ? STUCK_VAL : 1'b0;
    end

    // State, counter, vector, status and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            vec_r       <= 4'd0;
            det_mask_r  <= 16'd0;
            det_count_r <= 5'd0;
            detected_r  <= 1'b0;
            first_vec_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            f_force_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            vec_r       <= vec_s;
            det_mask_r  <= det_mask_s;
            det_count_r <= det_count_s;
            detected_r  <= detected_s;
            first_vec_r <= first_vec_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            f_force_r   <= f_force_s;
        end
    end

    assign vec       = vec_r;
    assign f_force   = f_force_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign detected  = detected_r;
    assign first_vec = first_vec_r;
    assign det_count = det_count_r;
    assign det_mask  = det_mask_r;

endmodule

// File: tb/tb_fault_test_seq.sv
// Scoreboard bench for fault_test_seq: two instances (SETTLE=1 stuck-at-0, SETTLE=3 stuck-at-1) driven by a small datapath model.
module tb_fault_test_seq;

    localparam int S1 = 1;
    localparam int S3 = 3;

    // Latency counted from the cycle in which start is presented to the cycle done is high.
`ifdef FTS_EARLY_STOP_EN
    localparam int          LAT1   = 5;        // stops at vec 1: 2*(1+1)+1
    localparam logic [15:0] MASK1  = 16'h0002;
    localparam logic [4:0]  CNT1   = 5'd1;
    localparam int          LAT3   = 5;        // stops at vec 0: 1*(3+1)+1
    localparam logic [15:0] MASK3  = 16'h0001;
    localparam logic [4:0]  CNT3   = 5'd1;
`else
    localparam int          LAT1   = 33;       // 16*(1+1)+1
    localparam logic [15:0] MASK1  = 16'hEEEE;
    localparam logic [4:0]  CNT1   = 5'd12;
    localparam int          LAT3   = 65;       // 16*(3+1)+1
    localparam logic [15:0] MASK3  = 16'h1111;
    localparam logic [4:0]  CNT3   = 5'd4;
`endif
    localparam int LAT_FULL1 = 33;

    typedef struct {
        int          due;
        logic [15:0] mask;
        logic [4:0]  cnt;
        logic        det;
        logic [3:0]  first;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic no_fault = 1'b0;
    logic zg1, zf1, zg3, zf3;
    logic [3:0]  vec1, vec3, first1, first3;
    logic        f1, f3, busy1, busy3, done1, done3, det1, det3;
    logic [4:0]  cnt1, cnt3;
    logic [15:0] mask1, mask3;

    exp_t q1[$];
    exp_t q3[$];
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    // Datapath model: net_f = C | D and Z = net_f, so the faulted copy outputs the forced value.
    assign zg1 = vec1[1] | vec1[0];
    assign zf1 = no_fault ? zg1 : f1;
    assign zg3 = vec3[1] | vec3[0];
    assign zf3 = f3;

    fault_test_seq #(.STUCK_VAL(1'b0), .SETTLE(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .z_good(zg1), .z_fault(zf1), .vec(vec1), .f_force(f1), .busy(busy1),
        .done(done1), .detected(det1), .first_vec(first1), .det_count(cnt1), .det_mask(mask1)
    );

    fault_test_seq #(.STUCK_VAL(1'b1), .SETTLE(S3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .z_good(zg3), .z_fault(zf3), .vec(vec3), .f_force(f3), .busy(busy3),
        .done(done3), .detected(det3), .first_vec(first3), .det_count(cnt3), .det_mask(mask3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", {31'd0, done1}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("done1_cycle", cyc, e.due);
                chk("done1_mask", {16'd0, mask1}, {16'd0, e.mask});
                chk("done1_count", {27'd0, cnt1}, {27'd0, e.cnt});
                chk("done1_first", {27'd0, det1, first1}, {27'd0, e.det, e.first});
            end
        end
        if (rst_n && done3) begin
            if (q3.size() == 0) begin
                chk("done3_unexpected", {31'd0, done3}, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("done3_cycle", cyc, e.due);
                chk("done3_mask", {16'd0, mask3}, {16'd0, e.mask});
                chk("done3_count", {27'd0, cnt3}, {27'd0, e.cnt});
                chk("done3_first", {27'd0, det3, first3}, {27'd0, e.det, e.first});
            end
        end
    end

    // Present start/abort for one cycle; sc is the cycle number in which they are presented.
    task automatic go(input logic s1, input logic a1, input logic s3, output int sc);
        @(negedge clk);
        sc = cyc;
        start1 = s1;
        abort1 = a1;
        start3 = s3;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q1.size() + q3.size(), 32'd0);
    endtask

    initial begin
        int sc;
        exp_t e;

        repeat (2) @(negedge clk);
        chk("rst_vec", {24'd0, vec1, vec3}, 32'd0);
        chk("rst_mask", {mask1, mask3}, 32'd0);
        chk("rst_cnt", {22'd0, cnt1, cnt3}, 32'd0);
        chk("rst_first", {24'd0, first1, first3}, 32'd0);
        chk("rst_flags", {24'd0, f1, busy1, done1, det1, f3, busy3, done3, det3}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweep on both instances, with a stray start re-pulsed mid-sweep.
        go(1'b1, 1'b0, 1'b1, sc);
        e = '{due: sc + LAT1, mask: MASK1, cnt: CNT1, det: 1'b1, first: 4'd1};
        q1.push_back(e);
        e = '{due: sc + LAT3, mask: MASK3, cnt: CNT3, det: 1'b1, first: 4'd0};
        q3.push_back(e);
        chk("busy_rise", {30'd0, busy1, busy3}, 32'd3);
        chk("f_force_busy", {30'd0, f1, f3}, 32'd1);
        repeat (2) @(negedge clk);
        chk("vec_step", {28'd0, vec1}, 32'd1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain(200);
        chk("busy_after_done", {30'd0, busy1, busy3}, 32'd0);
        chk("f_force_idle", {30'd0, f1, f3}, 32'd0);
        chk("mask_retained", {16'd0, mask1}, {16'd0, MASK1});

        // start and abort together in IDLE: no sweep, results untouched.
        go(1'b1, 1'b1, 1'b0, sc);
        chk("start_abort_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        chk("start_abort_idle", {31'd0, busy1}, 32'd0);
        chk("start_abort_mask", {16'd0, mask1}, {16'd0, MASK1});

        // No-fault case; the new start also clears the previous results.
        no_fault = 1'b1;
        go(1'b1, 1'b0, 1'b0, sc);
        e = '{due: sc + LAT_FULL1, mask: 16'h0000, cnt: 5'd0, det: 1'b0, first: 4'd0};
        q1.push_back(e);
        drain(200);
        no_fault = 1'b0;

`ifndef FTS_EARLY_STOP_EN
        // Abort while vec 5 is in WAIT: partial results kept, no done.
        go(1'b1, 1'b0, 1'b0, sc);
        repeat (10) @(negedge clk);
        chk("abort_at_vec", {27'd0, busy1, vec1}, {27'd0, 1'b1, 4'd5});
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", {30'd0, busy1, done1}, 32'd0);
        chk("abort_mask", {16'd0, mask1}, 32'h0000_000E);
        chk("abort_count", {27'd0, cnt1}, 32'd3);
        chk("abort_first", {27'd0, det1, first1}, {27'd0, 1'b1, 4'd1});
        repeat (4) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy1}, 32'd0);
`endif

        // Asynchronous reset between edges mid-sweep.
        go(1'b1, 1'b0, 1'b1, sc);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", {29'd0, busy1, busy3, f3}, 32'd7);
        rst_n = 1'b0;
        #1;
        q1.delete();
        q3.delete();
        chk("arst_vec", {24'd0, vec1, vec3}, 32'd0);
        chk("arst_mask", {mask1, mask3}, 32'd0);
        chk("arst_cnt", {22'd0, cnt1, cnt3}, 32'd0);
        chk("arst_flags", {24'd0, f1, busy1, done1, det1, f3, busy3, done3, det3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        go(1'b1, 1'b0, 1'b1, sc);
        e = '{due: sc + LAT1, mask: MASK1, cnt: CNT1, det: 1'b1, first: 4'd1};
        q1.push_back(e);
        e = '{due: sc + LAT3, mask: MASK3, cnt: CNT3, det: 1'b1, first: 4'd0};
        q3.push_back(e);
        drain(200);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
